// File: rtl/instr_prefetch_buffer_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
// The buffer stores PC and instruction together as one FIFO entry.
package instr_prefetch_buffer_pkg;
  localparam int          ADDR_W   = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [31:0]       instr;
  } entry_t;

  function automatic logic [ADDR_W-1:0] wordAlign(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with registered storage and a synchronous clear.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wrPtr, rdPtr;
  logic                        full, doPush, doPop;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign doPop  = pop && !empty;
  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign doPush = push && (!full || doPop);
  assign rdata  = mem[rdPtr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (clear) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      count <= count + CW'(doPush) - CW'(doPop);
    end
  end

  always_ff @(posedge clk) begin
    if (doPush && !clear) mem[wrPtr] <= wdata;
  end
endmodule

// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer: issues sequential fetches, queues in-order
// responses with their PCs, and flushes/refetches on redirect.
module instr_prefetch_buffer
  import instr_prefetch_buffer_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = 3;
  localparam int QW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  logic [ADDR_W-1:0]               fetchPc;
  logic [OW-1:0]                   outstanding, dropCount;
  logic [MAX_OUT-1:0][ADDR_W-1:0]  pcQ;
  logic [QW-1:0]                   qWr, qRd;
  logic [CW-1:0]                   fifoCount;
  logic                            xfer, push, pop, fifoEmpty;
  entry_t                          head, pushEntry;

  // Requests are held off during reset so the port is quiet while rst is low.
  assign imem_req_valid = rst && !redirect_valid
                          && (int'(fifoCount) + int'(outstanding) < DEPTH)
                          && (int'(outstanding) < MAX_OUT);
  assign imem_req_addr  = fetchPc;
  assign xfer = imem_req_valid && imem_req_ready;
  assign push = imem_rsp_valid && (dropCount == '0) && !redirect_valid;
  assign pop  = instr_valid && instr_ready && !redirect_valid;
  assign pushEntry = '{pc: pcQ[qRd], instr: imem_rsp_data};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetchPc     <= RESET_PC;
      outstanding <= '0;
      dropCount   <= '0;
      qWr         <= '0;
      qRd         <= '0;
    end else begin
      outstanding <= outstanding + OW'(xfer) - OW'(imem_rsp_valid);
      if (xfer)           qWr <= (qWr == QW'(MAX_OUT - 1)) ? '0 : qWr + QW'(1);
      // Dropped responses still retire their in-flight PC slot.
      if (imem_rsp_valid) qRd <= (qRd == QW'(MAX_OUT - 1)) ? '0 : qRd + QW'(1);
      if (redirect_valid) begin
        fetchPc   <= wordAlign(redirect_pc);
        dropCount <= outstanding - OW'(imem_rsp_valid);
      end else begin
        if (xfer) fetchPc <= fetchPc + 32'd4;
        if (imem_rsp_valid && (dropCount != '0)) dropCount <= dropCount - OW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) pcQ[qWr] <= fetchPc;
  end

  sync_fifo #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) uFifo (
    .clk   (clk),
    .rst   (rst),
    .clear (redirect_valid),
    .push  (push),
    .wdata (pushEntry),
    .pop   (pop),
    .rdata (head),
    .empty (fifoEmpty),
    .count (fifoCount)
  );

  assign instr_valid    = !fifoEmpty;
  assign instr_out      = instr_valid ? head.instr : NOP_INSTR;
  assign instr_pc       = instr_valid ? head.pc : 32'h0;
  assign instr_pc_plus4 = instr_pc + 32'd4;
endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Randomized bench for instr_prefetch_buffer with an in-order memory model
// and a fetch-path reference model (expected PC stream and occupancy).
module tb_instr_prefetch_buffer;
  import instr_prefetch_buffer_pkg::*;

  localparam int          DEPTH    = 4;
  localparam int          MAX_OUT  = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0, rst;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        redirect_valid, instr_valid, instr_ready;
  logic [31:0] redirect_pc, instr_out, instr_pc, instr_pc_plus4;

  instr_prefetch_buffer #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_out(instr_out), .instr_pc(instr_pc), .instr_pc_plus4(instr_pc_plus4)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int epoch; int due; } memReq_t;
  memReq_t     memQ[$];
  int          cyc, lastDue, epoch, occ;
  int          readyPct, takePct, latMin, latExtra;
  logic [31:0] fetchExp, headExp;
  int          nCmp, nFail;
  logic        sawPop, sawReq;
  logic [31:0] popPc, popP4;

  function automatic logic [31:0] memData(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_0F0F;
  endfunction

  // One clock cycle: drive inputs, compare against the model, advance the model.
  task automatic run_cycle(input logic redir, input logic [31:0] rpc);
    logic        take, rsp, xfer, expReq;
    logic [31:0] expPc, expInstr;
    memReq_t     r, e;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_req_ready = ($urandom_range(99) < readyPct);
    take           = ($urandom_range(99) < takePct);
    instr_ready    = take;
    rsp            = (memQ.size() > 0) && (memQ[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? memData(memQ[0].addr) : $urandom;
    #1;
    expReq   = !redir && (occ + memQ.size() < DEPTH) && (memQ.size() < MAX_OUT);
    expPc    = (occ > 0) ? headExp : 32'h0;
    expInstr = (occ > 0) ? memData(headExp) : NOP_INSTR;
    nCmp++;
    if (instr_valid !== (occ > 0)) begin
      nFail++; $display("FAIL instr_valid cyc=%0d got %b want %b", cyc, instr_valid, occ > 0);
    end
    nCmp++;
    if (instr_pc !== expPc) begin
      nFail++; $display("FAIL instr_pc cyc=%0d got %h want %h", cyc, instr_pc, expPc);
    end
    nCmp++;
    if (instr_out !== expInstr) begin
      nFail++; $display("FAIL instr_out cyc=%0d got %h want %h", cyc, instr_out, expInstr);
    end
    nCmp++;
    if (instr_pc_plus4 !== expPc + 32'd4) begin
      nFail++; $display("FAIL pc_plus4 cyc=%0d got %h want %h", cyc, instr_pc_plus4, expPc + 32'd4);
    end
    nCmp++;
    if (imem_req_valid !== expReq) begin
      nFail++; $display("FAIL req_valid cyc=%0d got %b want %b", cyc, imem_req_valid, expReq);
    end
    if (expReq) begin
      nCmp++;
      if (imem_req_addr !== fetchExp) begin
        nFail++; $display("FAIL req_addr cyc=%0d got %h want %h", cyc, imem_req_addr, fetchExp);
      end
    end
    xfer   = (imem_req_valid === 1'b1) && imem_req_ready;
    sawReq = imem_req_valid;
    sawPop = (occ > 0) && take && !redir;
    popPc  = instr_pc;
    popP4  = instr_pc_plus4;
    if (sawPop) begin occ--; headExp += 32'd4; end
    if (rsp) begin
      e = memQ.pop_front();
      if (e.epoch == epoch && !redir) occ++;
    end
    if (xfer) begin
      r.addr  = imem_req_addr;
      r.epoch = epoch;
      r.due   = cyc + latMin + int'($urandom_range(latExtra));
      if (r.due <= lastDue) r.due = lastDue + 1;
      lastDue = r.due;
      memQ.push_back(r);
      fetchExp += 32'd4;
    end
    if (redir) begin
      occ = 0; epoch++;
      fetchExp = {rpc[31:2], 2'b00};
      headExp  = fetchExp;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  // Holds rst low (already asserted) for two edges, resets the models, releases.
  task automatic hold_reset();
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
    redirect_valid = 0; redirect_pc = 0; instr_ready = 0;
    memQ.delete(); occ = 0; epoch++;
    fetchExp = RESET_PC; headExp = RESET_PC;
    @(posedge clk); @(posedge clk); #1;
    cyc += 2; lastDue = cyc;
    rst = 1'b1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    hold_reset();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    nCmp += 6;
    if (imem_req_valid !== 1'b0) begin nFail++; $display("FAIL rst_req_valid got %b want 0", imem_req_valid); end
    if (imem_req_addr !== RESET_PC) begin nFail++; $display("FAIL rst_req_addr got %h want %h", imem_req_addr, RESET_PC); end
    if (instr_valid !== 1'b0) begin nFail++; $display("FAIL rst_instr_valid got %b want 0", instr_valid); end
    if (instr_out !== 32'h13) begin nFail++; $display("FAIL rst_instr_out got %h want 00000013", instr_out); end
    if (instr_pc !== 32'h0) begin nFail++; $display("FAIL rst_instr_pc got %h want 0", instr_pc); end
    if (instr_pc_plus4 !== 32'h4) begin nFail++; $display("FAIL rst_pc_plus4 got %h want 4", instr_pc_plus4); end
    hold_reset();
    #1;
    nCmp++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
      nFail++; $display("FAIL first_req got %b/%h want 1/%h", imem_req_valid, imem_req_addr, RESET_PC);
    end
  endtask

  task automatic test_steady_flow();
    int got, firstCyc;
    readyPct = 100; takePct = 100; latMin = 1; latExtra = 0;
    apply_reset();
    got = 0; firstCyc = 0;
    for (int i = 0; i < 20 && got < 4; i++) begin
      run_cycle(1'b0, 32'h0);
      if (sawPop) begin
        if (got == 0) firstCyc = i;
        nCmp++;
        if (popPc !== 32'(got * 4) || i != firstCyc + got) begin
          nFail++; $display("FAIL steady pop%0d got %h@%0d want %h@%0d", got, popPc, i, got * 4, firstCyc + got);
        end
        got++;
      end
    end
    nCmp++;
    if (got != 4) begin nFail++; $display("FAIL steady_timeout got %0d pops want 4", got); end
  endtask

  task automatic test_stall();
    readyPct = 100; takePct = 0; latMin = 1; latExtra = 0;
    apply_reset();
    for (int i = 0; i < 10; i++) run_cycle(1'b0, 32'h0);
    nCmp++;
    if (sawReq !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
      nFail++; $display("FAIL stall_hold got req=%b v=%b pc=%h want 0/1/0", sawReq, instr_valid, instr_pc);
    end
    takePct = 100;
    for (int i = 0; i < 4; i++) begin
      run_cycle(1'b0, 32'h0);
      nCmp++;
      if (sawPop !== 1'b1 || popPc !== 32'(i * 4)) begin
        nFail++; $display("FAIL stall_drain%0d got %b/%h want 1/%h", i, sawPop, popPc, i * 4);
      end
    end
  endtask

  task automatic test_redirect();
    int got;
    readyPct = 100; takePct = 100; latMin = 3; latExtra = 0;
    apply_reset();
    run_cycle(1'b0, 32'h0);
    run_cycle(1'b0, 32'h0);
    nCmp++;
    if (memQ.size() != 2) begin nFail++; $display("FAIL redir_setup got %0d in flight want 2", memQ.size()); end
    run_cycle(1'b1, 32'h0000_0103);
    got = 0;
    for (int i = 0; i < 30 && got < 2; i++) begin
      run_cycle(1'b0, 32'h0);
      if (sawPop) begin
        nCmp++;
        if (popPc !== 32'h100 + 32'(got * 4)) begin
          nFail++; $display("FAIL redir_pop%0d got %h want %h", got, popPc, 32'h100 + 32'(got * 4));
        end
        got++;
      end
    end
    nCmp++;
    if (got != 2) begin nFail++; $display("FAIL redir_timeout got %0d pops want 2", got); end
  endtask

  task automatic test_simul_redirect();
    int got;
    readyPct = 100; takePct = 100; latMin = 1; latExtra = 0;
    apply_reset();
    for (int i = 0; i < 5; i++) run_cycle(1'b0, 32'h0);
    nCmp++;
    if (!(occ > 0 && memQ.size() > 0 && memQ[0].due <= cyc)) begin
      nFail++; $display("FAIL simul_setup got occ=%0d inflight=%0d want push+pop ready", occ, memQ.size());
    end
    run_cycle(1'b1, 32'h0000_0200);
    nCmp++;
    if (instr_valid !== 1'b0) begin nFail++; $display("FAIL simul_empty got %b want 0", instr_valid); end
    got = 0;
    for (int i = 0; i < 20 && got < 1; i++) begin
      run_cycle(1'b0, 32'h0);
      if (sawPop) got++;
    end
    nCmp++;
    if (got != 1 || popPc !== 32'h200) begin
      nFail++; $display("FAIL simul_first got %0d/%h want 1/00000200", got, popPc);
    end
  endtask

  task automatic test_wrap();
    int got;
    logic [31:0] want;
    readyPct = 100; takePct = 100; latMin = 1; latExtra = 0;
    run_cycle(1'b1, 32'hFFFF_FFF8);
    got = 0;
    for (int i = 0; i < 20 && got < 3; i++) begin
      run_cycle(1'b0, 32'h0);
      if (sawPop) begin
        want = 32'hFFFF_FFF8 + 32'(got * 4);
        nCmp++;
        if (popPc !== want) begin nFail++; $display("FAIL wrap_pop%0d got %h want %h", got, popPc, want); end
        if (got == 1) begin
          nCmp++;
          if (popP4 !== 32'h0) begin nFail++; $display("FAIL wrap_plus4 got %h want 0", popP4); end
        end
        got++;
      end
    end
    nCmp++;
    if (got != 3) begin nFail++; $display("FAIL wrap_timeout got %0d pops want 3", got); end
  endtask

  task automatic test_async_reset();
    readyPct = 100; takePct = 50; latMin = 2; latExtra = 1;
    for (int i = 0; i < 12; i++) run_cycle(1'b0, 32'h0);
    #2 rst = 1'b0;
    #1;
    nCmp += 5;
    if (imem_req_valid !== 1'b0) begin nFail++; $display("FAIL arst_req_valid got %b want 0", imem_req_valid); end
    if (imem_req_addr !== RESET_PC) begin nFail++; $display("FAIL arst_req_addr got %h want %h", imem_req_addr, RESET_PC); end
    if (instr_valid !== 1'b0) begin nFail++; $display("FAIL arst_instr_valid got %b want 0", instr_valid); end
    if (instr_out !== NOP_INSTR || instr_pc !== 32'h0) begin
      nFail++; $display("FAIL arst_head got %h/%h want 00000013/0", instr_out, instr_pc);
    end
    if (instr_pc_plus4 !== 32'h4) begin nFail++; $display("FAIL arst_plus4 got %h want 4", instr_pc_plus4); end
    hold_reset();
    for (int i = 0; i < 10; i++) run_cycle(1'b0, 32'h0);
  endtask

  task automatic test_random();
    logic [31:0] rpc;
    readyPct = 60; takePct = 60; latMin = 1; latExtra = 3;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(99) < 4) begin
        rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1F)) : $urandom;
        run_cycle(1'b1, rpc);
      end else begin
        run_cycle(1'b0, 32'h0);
      end
      if (i % 100 == 50) begin readyPct = $urandom_range(30, 100); takePct = $urandom_range(30, 100); end
    end
  endtask

  initial begin
    nCmp = 0; nFail = 0; cyc = 0; lastDue = 0; epoch = 0; occ = 0;
    readyPct = 100; takePct = 100; latMin = 1; latExtra = 0;
    test_reset();
    test_steady_flow();
    test_stall();
    test_redirect();
    test_simul_redirect();
    test_wrap();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end
endmodule

// File: doc/instr_prefetch_buffer.md
INSTR_PREFETCH_BUFFER -- requirements
Module: instr_prefetch_buffer

Interface
REQ-001 Parameter DEPTH, default 4: FIFO entries; power of two, 2 to 16.
REQ-002 Parameter MAX_OUT, default 2: maximum outstanding imem requests, 1 to 4.
REQ-003 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous, active-low.
REQ-006 Port imem_req_valid, output, 1: fetch request valid.
REQ-007 Port imem_req_addr, output, 32: word-aligned fetch address.
REQ-008 Port imem_req_ready, input, 1: memory accepts the request.
REQ-009 Port imem_rsp_valid, input, 1: in-order response valid, latency of 1 or more cycles.
REQ-010 Port imem_rsp_data, input, 32: instruction word.
REQ-011 Port redirect_valid, input, 1: flush and refetch (branch, jal or jalr taken; mispredict).
REQ-012 Port redirect_pc, input, 32: new fetch address; bits [1:0] ignored.
REQ-013 Port instr_valid, output, 1: head entry valid toward the fetch/decode register.
REQ-014 Port instr_ready, input, 1: consumer takes the head entry (low means stall).
REQ-015 Port instr_out, output, 32: head instruction; 32'h0000_0013 (NOP) when empty.
REQ-016 Port instr_pc, output, 32: PC of head instruction; 0 when empty.
REQ-017 Port instr_pc_plus4, output, 32: instr_pc + 4, modulo 2^32.

Function
REQ-018 Request handshake: a request transfers when imem_req_valid and imem_req_ready are both high; imem_req_addr stays stable while valid is high and ready is low.
REQ-019 Issue condition: imem_req_valid = !redirect_valid && (fifo_count + outstanding < DEPTH) && (outstanding < MAX_OUT).
REQ-020 Fetch PC: advances by 4 on each transfer and wraps 32'hFFFF_FFFC to 32'h0.
REQ-021 Outstanding counter: +1 on a transfer, -1 on imem_rsp_valid; both in one cycle leaves it unchanged.
REQ-022 Push: an accepted response with drop_count == 0 pushes {pc, data}; pc comes from an internal in-flight PC queue of MAX_OUT entries.
REQ-023 Pop: occurs when instr_valid && instr_ready; push and pop in one cycle leave fifo_count unchanged, including when full or when empty with bypass disabled.
REQ-024 Output timing: the head is registered; a pushed entry appears at instr_valid no earlier than the next cycle (no combinational response-to-output path).
REQ-025 Redirect, same edge: FIFO cleared; fetch PC set to {redirect_pc[31:2], 2'b00}; drop_count set to outstanding minus any response in that cycle; pop and push in that cycle discarded.
REQ-026 Drop: while drop_count > 0, each imem_rsp_valid decrements drop_count and is discarded.
REQ-027 Post-redirect issue: the first request after a redirect issues the cycle after redirect_valid; instr_valid is 0 until the first new-path response is pushed.
REQ-028 Back-to-back redirects: the latest one wins and drop_count accumulates correctly.
REQ-029 Full FIFO: no request issues; responses can never overflow, by REQ-019.
REQ-030 Stall: instr_out, instr_pc and instr_valid hold while instr_ready is low.

Reset
REQ-031 While rst is low: imem_req_valid=0, imem_req_addr=RESET_PC, instr_valid=0, instr_out=32'h13, instr_pc=0, instr_pc_plus4=4, fifo_count=0, outstanding=0, drop_count=0, fetch PC=RESET_PC.
REQ-032 Reset mid-transaction: any in-flight memory responses after rst deassertion are the memory's responsibility (memory is reset together); the buffer treats outstanding as 0.
REQ-033 First request: issues in the first cycle after rst goes high.

Structure
REQ-034 Shared package: NOP encoding 32'h0000_0013, address width 32, and an entry struct {pc[31:0], instr[31:0]}.
REQ-035 Sub-module: one generic synchronous FIFO, sync_fifo (parameters WIDTH and DEPTH, with clear input), instantiated for entries; counters and the in-flight PC queue stay in the top level.

Verification
REQ-036 Reset then steady flow: ready=1, 1-cycle memory, instr_ready=1 -> instr_pc sequence 0, 4, 8, 12 on consecutive cycles after fill; no bubbles.
REQ-037 Stall: instr_ready=0 for 10 cycles -> fifo_count reaches 4, imem_req_valid=0, instr_pc held at 0; release -> drains 0, 4, 8, 12 in order.
REQ-038 Redirect with 2 outstanding (3-cycle latency): redirect_pc=32'h0000_0103 -> both old responses dropped; next instr_pc=32'h100, then 32'h104.
REQ-039 Simultaneous redirect, push and pop in one cycle -> FIFO empty next cycle; no stale PC ever reaches instr_pc.
REQ-040 Wrap: redirect_pc=32'hFFFF_FFF8 -> instr_pc FFFF_FFF8, FFFF_FFFC, 0000_0000; instr_pc_plus4 for FFFF_FFFC = 0.
REQ-041 Asynchronous reset asserted mid-stream -> outputs reach REQ-031 values immediately without a clock edge; fetch restarts at RESET_PC.
